// File: rtl/sia_rxq.sv
// sia_rxq: 16-bit receive queue between the SIA deserializer and the sia_wb slave.
// Optional macro SIA_RXQ_OVERRUN_EN adds the sticky overrun flag and its clear input.
`default_nettype none

module sia_rxq #(
  parameter int DEPTH_LOG2 = 4,
  parameter int HIWAT      = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  rxd_we_i,
  input  logic [15:0]           rxd_dat_i,
  input  logic                  rxq_pop_i,
  input  logic                  rxq_oe_i,
  input  logic                  rxq_clr_ovr_i,
  output logic [15:0]           rxq_dat_o,
  output logic                  rxq_full_o,
  output logic                  rxq_not_empty_o,
  output logic                  rxq_hiwat_o,
  output logic [DEPTH_LOG2:0]   rxq_count_o,
  output logic                  rxq_overrun_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] HIWAT_CNT = (DEPTH_LOG2 + 1)'(HIWAT);

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2:0]   count;

  logic full;
  logic not_empty;
  logic pop_ok;
  logic push_ok;
  logic drop;

  assign full      = (count == DEPTH_CNT);
  assign not_empty = (count != '0);
  assign pop_ok    = rxq_pop_i & not_empty;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign push_ok   = rxd_we_i & (~full | pop_ok);
  assign drop      = rxd_we_i & ~push_ok;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wp] <= rxd_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop_ok) begin
        rp <= rp + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SIA_RXQ_OVERRUN_EN
  logic overrun;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (rxq_clr_ovr_i) begin
      overrun <= 1'b0;
    end
  end

  assign rxq_overrun_o = overrun;
`else
  logic ovr_unused;
  assign ovr_unused    = &{1'b0, rxq_clr_ovr_i, drop};
  assign rxq_overrun_o = 1'b0;
`endif

  assign rxq_dat_o       = (rxq_oe_i && not_empty) ? mem[rp] : 16'h0000;
  assign rxq_full_o      = full;
  assign rxq_not_empty_o = not_empty;
  assign rxq_hiwat_o     = (count >= HIWAT_CNT);
  assign rxq_count_o     = count;

endmodule

`default_nettype wire

// File: tb/tb_sia_rxq.sv
// tb_sia_rxq: directed bench for sia_rxq with a queue scoreboard of expected head words.
`default_nettype none

module tb_sia_rxq;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int HIWAT      = 8;
`ifdef SIA_RXQ_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic                clk;
  logic                reset_n;
  logic                rxd_we;
  logic [15:0]         rxd_dat;
  logic                rxq_pop;
  logic                rxq_oe;
  logic                clr_ovr;
  logic [15:0]         dat;
  logic                full;
  logic                not_empty;
  logic                hiwat;
  logic [DEPTH_LOG2:0] count;
  logic                overrun;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] sb[$];
  logic        ovr_model = 1'b0;

  sia_rxq #(.DEPTH_LOG2(DEPTH_LOG2), .HIWAT(HIWAT)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .rxd_we_i       (rxd_we),
    .rxd_dat_i      (rxd_dat),
    .rxq_pop_i      (rxq_pop),
    .rxq_oe_i       (rxq_oe),
    .rxq_clr_ovr_i  (clr_ovr),
    .rxq_dat_o      (dat),
    .rxq_full_o     (full),
    .rxq_not_empty_o(not_empty),
    .rxq_hiwat_o    (hiwat),
    .rxq_count_o    (count),
    .rxq_overrun_o  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard model.
  task automatic check_all(input string tag);
    logic [15:0] head;
    head = (rxq_oe && sb.size() != 0) ? sb[0] : 16'h0000;
    chk({tag, ".count"},     32'(count),     32'(sb.size()));
    chk({tag, ".full"},      32'(full),      32'(sb.size() == DEPTH));
    chk({tag, ".not_empty"}, 32'(not_empty), 32'(sb.size() != 0));
    chk({tag, ".hiwat"},     32'(hiwat),     32'(sb.size() >= HIWAT));
    chk({tag, ".overrun"},   32'(overrun),   32'(ovr_model));
    chk({tag, ".dat"},       32'(dat),       32'(head));
  endtask

  // Drive one clocked transaction at a negedge; outputs are settled at the next negedge.
  task automatic cycle(input logic we, input logic [15:0] d, input logic pop, input logic clr);
    bit p_ok, w_ok, dr;
    rxd_we  = we;
    rxd_dat = d;
    rxq_pop = pop;
    clr_ovr = clr;
    p_ok = pop && (sb.size() != 0);
    w_ok = we && ((sb.size() < DEPTH) || p_ok);
    dr   = we && !w_ok;
    @(posedge clk);
    if (p_ok) void'(sb.pop_front());
    if (w_ok) sb.push_back(d);
    if (OVR_EN) begin
      if (dr) ovr_model = 1'b1;
      else if (clr) ovr_model = 1'b0;
    end
    @(negedge clk);
    rxd_we  = 1'b0;
    rxd_dat = 16'h0000;
    rxq_pop = 1'b0;
    clr_ovr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    rxd_we  = 1'b0;
    rxd_dat = 16'h0000;
    rxq_pop = 1'b0;
    rxq_oe  = 1'b0;
    clr_ovr = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all("idle");
    rxq_oe = 1'b1;
    #1;
    chk("oe_empty.dat", 32'(dat), 32'h0000);

    cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("two.count", 32'(count), 32'd2);
    chk("two.dat", 32'(dat), 32'hA5A5);
    check_all("two");
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("pop1.dat", 32'(dat), 32'h1234);
    check_all("pop1");
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("pop2.dat", 32'(dat), 32'h0000);
    check_all("pop2");

    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0);
      chk("fill.hiwat", 32'(hiwat), 32'((i + 1) >= 8));
      check_all("fill");
    end
    chk("fill.full", 32'(full), 32'd1);

    cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
    chk("drop.count", 32'(count), 32'd16);
    chk("drop.overrun", 32'(overrun), 32'(OVR_EN));
    chk("drop.dat", 32'(dat), 32'h0000);
    check_all("drop");
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("clr.overrun", 32'(overrun), 32'd0);

    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("pp_full.count", 32'(count), 32'd16);
    chk("pp_full.overrun", 32'(overrun), 32'd0);
    chk("pp_full.dat", 32'(dat), 32'h0001);
    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle(1'b0, 16'h0000, 1'b1, 1'b0);
      check_all("drain");
    end
    chk("wrap.dat", 32'(dat), 32'hBEEF);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    check_all("drained");

    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("pop_empty.count", 32'(count), 32'd0);
    cycle(1'b1, 16'h00C3, 1'b1, 1'b0);
    chk("pp_empty.count", 32'(count), 32'd1);
    chk("pp_empty.dat", 32'(dat), 32'h00C3);

    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    end
    chk("five.count", 32'(count), 32'd5);
    check_all("five");

    // Asynchronous reset between edges must clear outputs before the next posedge.
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    ovr_model = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    chk("post_rst.dat", 32'(dat), 32'h5555);
    check_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sia_rxq.md
# sia_rxq

Receive queue for the SIA serial interface. Sits between the SIA receiver's deserializer, which pushes completed 16-bit frames, and the `sia_wb` Wishbone slave, which reads the head word through `rxq_dat_o`/`rxq_oe_i` and pops it with `rxq_pop_i`. Provides full, not-empty, occupancy and high-water status for the Wishbone status register, interrupts and DMA requests.

## Interface
- `DEPTH_LOG2`, 4, log2 of the number of entries (16 entries by default).
- `HIWAT`, 8, occupancy at or above which `rxq_hiwat_o` asserts; legal range 1..2^DEPTH_LOG2.

- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `reset_ni`  in  1  reset, asynchronous assert, active-low.
- `rxd_we_i`  in  1  receiver pushes `rxd_dat_i` this cycle.
- `rxd_dat_i`  in  16  received frame, LSB-aligned.
- `rxq_pop_i`  in  1  discard the head entry this cycle.
- `rxq_oe_i`  in  1  drive the head word onto `rxq_dat_o`.
- `rxq_clr_ovr_i`  in  1  clear the sticky overrun flag.
- `rxq_dat_o`  out  16  head word when `rxq_oe_i` and not empty, else 0.
- `rxq_full_o`  out  1  count == 2^DEPTH_LOG2.
- `rxq_not_empty_o`  out  1  count != 0.
- `rxq_hiwat_o`  out  1  count >= HIWAT.
- `rxq_count_o`  out  DEPTH_LOG2+1  current occupancy.
- `rxq_overrun_o`  out  1  sticky: a push was dropped because the queue was full.

## Operation
- Storage: 2^DEPTH_LOG2 × 16 register array. Write pointer, read pointer and count are all registered.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. Count is DEPTH_LOG2+1 bits and saturates neither high nor low.
- Push accepted when `rxd_we_i` and (not full, or `rxq_pop_i` with count != 0). An accepted push writes `mem[wp]` and increments `wp`.
- Pop accepted when `rxq_pop_i` and count != 0. It increments `rp`. A pop while empty is ignored; nothing changes.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - unchanged when push and pop are both accepted.
- Simultaneous push and pop while full: both are accepted and count stays 2^DEPTH_LOG2.
- Simultaneous push and pop while empty: the pop is ignored and the push is accepted, so count becomes 1.
- Push while full without an accepted pop: the word is dropped, pointers and count are unchanged, and the overrun flag sets.
- Overrun flag: set by a dropped push, cleared by `rxq_clr_ovr_i`. If set and clear occur in the same cycle, set wins.
- `rxq_dat_o` is combinational from `mem[rp]`, gated by `rxq_oe_i` and not-empty. It is 0 when empty, even if stale data remains in storage.
- All status outputs are combinational decodes of the registered count and flag.

## Timing
- Reset (`reset_ni` low, asynchronous): `wp`, `rp` and count go to 0, and the overrun flag goes to 0. Consequently `rxq_full_o`=0, `rxq_not_empty_o`=0, `rxq_hiwat_o`=0, `rxq_count_o`=0 and `rxq_dat_o`=0. Memory contents are not reset.
- Reset asserted mid-operation discards all queued data immediately. Reset deassertion is synchronised by the system; there is no requirement inside this block.
- Write-to-visibility: a word pushed at edge N appears on `rxq_dat_o` (when it is the head) and in the status outputs after edge N, so it is readable in the cycle following the push.
- Pop latency: after a pop at edge N, the next head word is on `rxq_dat_o` in the cycle after edge N.
- `sia_wb` asserts pop for one cycle per Wishbone read of the data register. A pop held high for consecutive cycles pops one entry per cycle until the queue is empty.

## Configuration
- `SIA_RXQ_OVERRUN_EN`
  - Defined: the sticky overrun flag and the `rxq_clr_ovr_i` behaviour above are implemented.
  - Undefined: no overrun register exists, `rxq_overrun_o` is tied to 0 and `rxq_clr_ovr_i` is ignored. Drop-on-full behaviour is unchanged.

## Test plan
- Reset then idle: every output is 0. Set `rxq_oe_i`=1 while empty: `rxq_dat_o`=16'h0000.
- Push 16'hA5A5 then 16'h1234, with `rxq_oe_i`=1:
  - after the pushes: count=2, `rxq_not_empty_o`=1, `rxq_dat_o`=16'hA5A5.
  - pop once: count=1, `rxq_dat_o`=16'h1234.
  - pop again: count=0, `rxq_dat_o`=0.
- Push 16 words 16'h0000..16'h000F:
  - `rxq_hiwat_o` rises when count reaches 8.
  - `rxq_full_o`=1 at count 16.
  - push 16'hFFFF: dropped, count stays 16, `rxq_overrun_o`=1, head still 16'h0000.
  - pulse `rxq_clr_ovr_i`: overrun clears.
- While full, push 16'hBEEF with a simultaneous pop:
  - count stays 16, `rxq_overrun_o` stays 0, head becomes 16'h0001.
  - popping through to the last entry yields 16'hBEEF, which confirms pointer wrap.
- Pop while empty leaves count=0. A simultaneous push 16'h00C3 and pop while empty gives count=1 and head 16'h00C3.
- Assert `reset_ni` low asynchronously, between clock edges, with 5 entries queued: all outputs go to 0 before the next edge. After release, a push of 16'h5555 reads back 16'h5555.
